// File: rtl/axis_load_scheduler_pkg.sv
// axis_load_scheduler_pkg
//   Shared definitions for the load/compute/output run sequencer:
//   default layer count, AXI-stream TID values of the three load streams,
//   and the sequencer state encoding.
package axis_load_scheduler_pkg;

  localparam int DEF_NUM_LAYERS = 4;

  // TIDs carried by the slave AXI-stream for each kind of load stream.
  localparam int WEIGHT_S_AXIS_ID = 0;
  localparam int BIAS_S_AXIS_ID   = 1;
  localparam int INPUT_S_AXIS_ID  = 2;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LD_W      = 4'd1,
    LD_B      = 4'd2,
    LD_IN     = 4'd3,
    COMP_GO   = 4'd4,
    COMP_WAIT = 4'd5,
    TX_GO     = 4'd6,
    TX_WAIT   = 4'd7,
    ERR       = 4'd8
  } load_sched_state;

endpackage

// File: rtl/axis_load_scheduler_chk.sv
// axis_load_scheduler_chk
//   Property checker attached to the scheduler outputs: start/done pulses are
//   mutually exclusive, layer_idx stays below NUM_LAYERS, and no transaction
//   is admitted while the error flag is up.
// Ports
//   clk, rst       clock and synchronous active-high reset of the observed block
//   remaining      scheduler outputs being observed
module axis_load_scheduler_chk #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_WDT  = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 comp_start,
  input logic                 outputs_tx_start,
  input logic                 seq_done,
  input logic                 rx_allow,
  input logic                 seq_err,
  input logic [LAYER_WDT-1:0] layer_idx
);

  // Output invariants sampled each cycle outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0({comp_start, outputs_tx_start, seq_done}));
      assert (int'(layer_idx) < NUM_LAYERS);
      assert (!(seq_err && rx_allow));
    end
  end

endmodule

// File: rtl/axis_load_scheduler.sv
// axis_load_scheduler
//   Sequences one inference run: per layer one weight stream then one bias
//   stream (plus one input stream on layer 0), then a compute pass; after the
//   last layer the output transmission is started. Out-of-order stream IDs or
//   receive completions of the wrong kind park the sequencer in a sticky ERR.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, err_clr           run start / error clear pulses
//   peek_tvalid, peek_tid    pending slave transfer, checked against expected_tid
//   weights_rx_*, inputs_rx_* slave interface receive status
//   comp_done, outputs_tx_done completion pulses from compute / output paths
//   rx_allow, expected_tid   admission control towards the slave interface
//   comp_start, outputs_tx_start one-cycle start pulses
//   layer_idx                current layer
//   seq_busy, seq_done, seq_err run status
module axis_load_scheduler
  import axis_load_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int LAYER_WDT  = 3,
  parameter int TID_WDT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 err_clr,
  input  logic                 peek_tvalid,
  input  logic [TID_WDT-1:0]   peek_tid,
  input  logic                 weights_rx_busy,
  input  logic                 weights_rx_done,
  input  logic                 weights_n_bias,
  input  logic                 inputs_rx_busy,
  input  logic                 inputs_rx_done,
  input  logic                 comp_done,
  input  logic                 outputs_tx_done,
  output logic                 rx_allow,
  output logic [TID_WDT-1:0]   expected_tid,
  output logic                 comp_start,
  output logic                 outputs_tx_start,
  output logic [LAYER_WDT-1:0] layer_idx,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_err
);

  localparam logic [LAYER_WDT-1:0] LAYER_ZERO = {LAYER_WDT{1'b0}};
  localparam logic [LAYER_WDT-1:0] LAYER_ONE  = LAYER_WDT'(1);
  localparam logic [LAYER_WDT-1:0] LAST_LAYER = LAYER_WDT'(NUM_LAYERS - 1);

  load_sched_state      state_r, next_s;
  logic [LAYER_WDT-1:0] layer_r, layer_next_s;
  logic                 rx_allow_r, rx_allow_next_s;
  logic [TID_WDT-1:0]   expected_tid_r;
  logic                 comp_start_r, outputs_tx_start_r;
  logic                 seq_busy_r, seq_done_r, seq_err_r, seq_done_next_s;
  logic                 tid_mismatch_s, wrong_w_s, wrong_b_s, wrong_in_s;

  // TID admitted while a given load state is active.
  function automatic logic [TID_WDT-1:0] tid_of(input load_sched_state st);
    case (st)
      LD_W:    tid_of = TID_WDT'(WEIGHT_S_AXIS_ID);
      LD_B:    tid_of = TID_WDT'(BIAS_S_AXIS_ID);
      LD_IN:   tid_of = TID_WDT'(INPUT_S_AXIS_ID);
      default: tid_of = {TID_WDT{1'b0}};
    endcase
  endfunction

  // A TID is only policed while a new transaction may still be admitted.
  assign tid_mismatch_s = rx_allow_r & peek_tvalid & (peek_tid != expected_tid_r);
  assign wrong_w_s  = inputs_rx_done | (weights_rx_done & ~weights_n_bias) | tid_mismatch_s;
  assign wrong_b_s  = inputs_rx_done | (weights_rx_done & weights_n_bias) | tid_mismatch_s;
  assign wrong_in_s = weights_rx_done | tid_mismatch_s;

  // Next-state, layer and admission decode.
  always_comb begin
    next_s          = state_r;
    layer_next_s    = layer_r;
    rx_allow_next_s = rx_allow_r;
    seq_done_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_s          = LD_W;
          layer_next_s    = LAYER_ZERO;
          rx_allow_next_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      LD_W: begin
        if (wrong_w_s) begin
          next_s          = ERR;
          rx_allow_next_s = 1'b0;
        end else if (weights_rx_done && weights_n_bias) begin
          next_s          = LD_B;
          rx_allow_next_s = 1'b1;
        end else if (weights_rx_busy) begin
          rx_allow_next_s = 1'b0;
        end else begin
          next_s = LD_W;
        end
      end
      LD_B: begin
        if (wrong_b_s) begin
          next_s          = ERR;
          rx_allow_next_s = 1'b0;
        end else if (weights_rx_done && !weights_n_bias) begin
          // The input activations are loaded once, ahead of the first layer.
          if (layer_r == LAYER_ZERO) begin
            next_s          = LD_IN;
            rx_allow_next_s = 1'b1;
          end else begin
            next_s          = COMP_GO;
            rx_allow_next_s = 1'b0;
          end
        end else if (weights_rx_busy) begin
          rx_allow_next_s = 1'b0;
        end else begin
          next_s = LD_B;
        end
      end
      LD_IN: begin
        if (wrong_in_s) begin
          next_s          = ERR;
          rx_allow_next_s = 1'b0;
        end else if (inputs_rx_done) begin
          next_s          = COMP_GO;
          rx_allow_next_s = 1'b0;
        end else if (inputs_rx_busy) begin
          rx_allow_next_s = 1'b0;
        end else begin
          next_s = LD_IN;
        end
      end
      COMP_GO: begin
        next_s = COMP_WAIT;
      end
      COMP_WAIT: begin
        if (comp_done) begin
          if (layer_r == LAST_LAYER) begin
            next_s = TX_GO;
          end else begin
            next_s          = LD_W;
            layer_next_s    = layer_r + LAYER_ONE;
            rx_allow_next_s = 1'b1;
          end
        end else begin
          next_s = COMP_WAIT;
        end
      end
      TX_GO: begin
        next_s = TX_WAIT;
      end
      TX_WAIT: begin
        if (outputs_tx_done) begin
          next_s          = IDLE;
          seq_done_next_s = 1'b1;
        end else begin
          next_s = TX_WAIT;
        end
      end
      ERR: begin
        // err_clr takes priority; a coincident start is dropped.
        if (err_clr) begin
          next_s       = IDLE;
          layer_next_s = LAYER_ZERO;
        end else begin
          next_s = ERR;
        end
      end
      default: begin
        next_s          = IDLE;
        layer_next_s    = LAYER_ZERO;
        rx_allow_next_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= IDLE;
      layer_r            <= LAYER_ZERO;
      rx_allow_r         <= 1'b0;
      expected_tid_r     <= {TID_WDT{1'b0}};
      comp_start_r       <= 1'b0;
      outputs_tx_start_r <= 1'b0;
      seq_busy_r         <= 1'b0;
      seq_done_r         <= 1'b0;
      seq_err_r          <= 1'b0;
    end else begin
      state_r            <= next_s;
      layer_r            <= layer_next_s;
      rx_allow_r         <= rx_allow_next_s;
      expected_tid_r     <= tid_of(next_s);
      comp_start_r       <= (next_s == COMP_GO);
      outputs_tx_start_r <= (next_s == TX_GO);
      seq_busy_r         <= (next_s != IDLE) && (next_s != ERR);
      seq_done_r         <= seq_done_next_s;
      seq_err_r          <= (next_s == ERR);
    end
  end

  assign rx_allow         = rx_allow_r;
  assign expected_tid     = expected_tid_r;
  assign comp_start       = comp_start_r;
  assign outputs_tx_start = outputs_tx_start_r;
  assign layer_idx        = layer_r;
  assign seq_busy         = seq_busy_r;
  assign seq_done         = seq_done_r;
  assign seq_err          = seq_err_r;

endmodule

// File: tb/tb_axis_load_scheduler.sv
// tb_axis_load_scheduler
//   Two schedulers (NUM_LAYERS=2 and NUM_LAYERS=1) share one stimulus stream.
//   A step-list reference model predicts every output of both every cycle;
//   a vector table and a few directed sequences add fixed expectations.
module tb_axis_load_scheduler;
  import axis_load_scheduler_pkg::*;

  localparam int LW = 3;
  localparam int TW = 2;
  // Step codes of the reference model's run script.
  localparam int C_W = 0, C_B = 1, C_I = 2, C_CG = 3, C_CW = 4, C_TG = 5, C_TW = 6;
  // Input vector bit masks.
  localparam logic [12:0] I_ST = 13'h1000, I_CLR = 13'h0800, I_PV = 13'h0400;
  localparam logic [12:0] I_TID1 = 13'h0100, I_TID2 = 13'h0200;
  localparam logic [12:0] I_WB = 13'h0080, I_WD = 13'h0040, I_WNB = 13'h0020;
  localparam logic [12:0] I_IB = 13'h0010, I_ID = 13'h0008, I_CD = 13'h0004, I_TD = 13'h0002;
  localparam int NROWS = 19;

  typedef struct packed {
    logic          rx_allow;
    logic [TW-1:0] tid;
    logic          cs;
    logic          ts;
    logic [LW-1:0] layer;
    logic          busy;
    logic          done;
    logic          err;
  } outs_t;

  typedef struct packed {
    logic [12:0] in;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, err_clr, peek_tvalid;
  logic [TW-1:0] peek_tid;
  logic weights_rx_busy, weights_rx_done, weights_n_bias;
  logic inputs_rx_busy, inputs_rx_done, comp_done, outputs_tx_done;

  logic          rx_allow_v [2];
  logic [TW-1:0] exp_tid_v [2];
  logic          comp_start_v [2];
  logic          tx_start_v [2];
  logic [LW-1:0] layer_v [2];
  logic          busy_v [2];
  logic          done_v [2];
  logic          err_v [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_load_scheduler #(.NUM_LAYERS(2 - g), .LAYER_WDT(LW), .TID_WDT(TW)) dut (
      .clk(clk), .rst(rst), .start(start), .err_clr(err_clr),
      .peek_tvalid(peek_tvalid), .peek_tid(peek_tid),
      .weights_rx_busy(weights_rx_busy), .weights_rx_done(weights_rx_done),
      .weights_n_bias(weights_n_bias), .inputs_rx_busy(inputs_rx_busy),
      .inputs_rx_done(inputs_rx_done), .comp_done(comp_done),
      .outputs_tx_done(outputs_tx_done),
      .rx_allow(rx_allow_v[g]), .expected_tid(exp_tid_v[g]),
      .comp_start(comp_start_v[g]), .outputs_tx_start(tx_start_v[g]),
      .layer_idx(layer_v[g]), .seq_busy(busy_v[g]), .seq_done(done_v[g]),
      .seq_err(err_v[g])
    );
    axis_load_scheduler_chk #(.NUM_LAYERS(2 - g), .LAYER_WDT(LW)) chk (
      .clk(clk), .rst(rst), .comp_start(comp_start_v[g]),
      .outputs_tx_start(tx_start_v[g]), .seq_done(done_v[g]),
      .rx_allow(rx_allow_v[g]), .seq_err(err_v[g]), .layer_idx(layer_v[g])
    );
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int m_nl [2] = '{2, 1};
  int m_active [2], m_err [2], m_k [2], m_allow [2], m_layer [2], m_done [2];
  int cnt_cs [2], cnt_ts [2], cnt_done [2];
  vec_t tbl [NROWS];

  // Run script: layer 0 = W,B,IN,CG,CW ; later layers = W,B,CG,CW ; then TG,TW.
  function automatic void decode(input int nl, input int k, output int code, output int lay);
    int j;
    if (k < 5) begin
      lay = 0;
      case (k)
        0: code = C_W;
        1: code = C_B;
        2: code = C_I;
        3: code = C_CG;
        default: code = C_CW;
      endcase
    end else begin
      j = k - 5;
      lay = 1 + j / 4;
      if (lay < nl) begin
        case (j % 4)
          0: code = C_W;
          1: code = C_B;
          2: code = C_CG;
          default: code = C_CW;
        endcase
      end else begin
        code = (k - 5 - 4 * (nl - 1) == 0) ? C_TG : C_TW;
        lay = nl - 1;
      end
    end
  endfunction

  function automatic int tid_for(input int code);
    if (code == C_W) return WEIGHT_S_AXIS_ID;
    if (code == C_B) return BIAS_S_AXIS_ID;
    return INPUT_S_AXIS_ID;
  endfunction

  function automatic void advance(input int d);
    int c, l;
    m_k[d]++;
    decode(m_nl[d], m_k[d], c, l);
    m_layer[d] = l;
    m_allow[d] = (c <= C_I) ? 1 : 0;
  endfunction

  function automatic void model_step(input int d);
    int code, lay;
    bit good, bad, bsy;
    if (rst) begin
      m_active[d] = 0; m_err[d] = 0; m_k[d] = 0;
      m_allow[d] = 0; m_layer[d] = 0; m_done[d] = 0;
      return;
    end
    m_done[d] = 0;
    if (m_err[d] != 0) begin
      if (err_clr) begin m_err[d] = 0; m_layer[d] = 0; end
    end else if (m_active[d] == 0) begin
      if (start) begin m_active[d] = 1; m_k[d] = 0; m_layer[d] = 0; m_allow[d] = 1; end
    end else begin
      decode(m_nl[d], m_k[d], code, lay);
      if (code <= C_I) begin
        bad = (m_allow[d] != 0) && peek_tvalid && (int'(peek_tid) != tid_for(code));
        if (code == C_W) begin
          good = weights_rx_done && weights_n_bias;
          bad  = bad || inputs_rx_done || (weights_rx_done && !weights_n_bias);
          bsy  = weights_rx_busy;
        end else if (code == C_B) begin
          good = weights_rx_done && !weights_n_bias;
          bad  = bad || inputs_rx_done || (weights_rx_done && weights_n_bias);
          bsy  = weights_rx_busy;
        end else begin
          good = inputs_rx_done;
          bad  = bad || weights_rx_done;
          bsy  = inputs_rx_busy;
        end
        if (bad) begin
          m_err[d] = 1; m_active[d] = 0; m_allow[d] = 0;
        end else if (good) begin
          advance(d);
        end else if (bsy) begin
          m_allow[d] = 0;
        end
      end else if (code == C_CG || code == C_TG) begin
        m_k[d]++;
      end else if (code == C_CW) begin
        if (comp_done) advance(d);
      end else begin
        if (outputs_tx_done) begin m_active[d] = 0; m_done[d] = 1; end
      end
    end
  endfunction

  function automatic outs_t model_outs(input int d);
    outs_t o;
    int code, lay;
    bit act;
    act = (m_active[d] != 0);
    decode(m_nl[d], m_k[d], code, lay);
    o.rx_allow = (m_allow[d] != 0);
    o.tid      = (act && code <= C_I) ? TW'(tid_for(code)) : 2'b00;
    o.cs       = act && (code == C_CG);
    o.ts       = act && (code == C_TG);
    o.layer    = LW'(m_layer[d]);
    o.busy     = act;
    o.done     = (m_done[d] != 0);
    o.err      = (m_err[d] != 0);
    return o;
  endfunction

  function automatic outs_t get_outs(input int d);
    outs_t o;
    o.rx_allow = rx_allow_v[d];
    o.tid      = exp_tid_v[d];
    o.cs       = comp_start_v[d];
    o.ts       = tx_start_v[d];
    o.layer    = layer_v[d];
    o.busy     = busy_v[d];
    o.done     = done_v[d];
    o.err      = err_v[d];
    return o;
  endfunction

  function automatic outs_t mk_out(input logic a, input int tid, input logic cs, input logic ts,
                                   input int layer, input logic busy, input logic done, input logic err);
    outs_t o;
    o.rx_allow = a; o.tid = TW'(tid); o.cs = cs; o.ts = ts;
    o.layer = LW'(layer); o.busy = busy; o.done = done; o.err = err;
    return o;
  endfunction

  task automatic cmp(input string name, input outs_t act, input outs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: actual=%b required=%b (allow,tid,cs,ts,layer,busy,done,err)", name, act, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [12:0] v);
    start = v[12]; err_clr = v[11]; peek_tvalid = v[10]; peek_tid = v[9:8];
    weights_rx_busy = v[7]; weights_rx_done = v[6]; weights_n_bias = v[5];
    inputs_rx_busy = v[4]; inputs_rx_done = v[3]; comp_done = v[2]; outputs_tx_done = v[1];
  endtask

  // One clock: advance the model, then check both DUTs against it.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      cnt_cs[d]   += int'(comp_start_v[d]);
      cnt_ts[d]   += int'(tx_start_v[d]);
      cnt_done[d] += int'(done_v[d]);
      if (chk_en) cmp($sformatf("model dut%0d", d), get_outs(d), model_outs(d));
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin cnt_cs[d] = 0; cnt_ts[d] = 0; cnt_done[d] = 0; end
  endtask

  task automatic run_table();
    for (int i = 0; i < NROWS; i++) begin
      drive(tbl[i].in);
      tick();
      cmp($sformatf("table row %0d", i), get_outs(0), tbl[i].exp);
    end
    drive(13'h0000);
  endtask

  task automatic gen_random();
    int code, lay;
    logic [12:0] v;
    v = 13'h0000;
    rst = ($urandom_range(199) == 0);
    if ($urandom_range(3) == 0) v |= I_ST;
    if ($urandom_range(1) == 0) v |= I_CLR;
    if ($urandom_range(2) == 0) v |= I_WB;
    if ($urandom_range(2) == 0) v |= I_IB;
    if ($urandom_range(3) == 0) begin
      v |= I_PV;
      v[9:8] = model_outs(0).tid;
    end
    if ($urandom_range(6) == 0) begin
      // Unconstrained garbage: any combination of completions and TIDs.
      v[9:8] = TW'($urandom_range(3));
      v[6:1] = 6'($urandom_range(63));
    end else if ($urandom_range(2) == 0) begin
      decode(m_nl[0], m_k[0], code, lay);
      case (code)
        C_W:     v |= I_WD | I_WNB;
        C_B:     v |= I_WD;
        C_I:     v |= I_ID;
        C_CW:    v |= I_CD;
        C_TW:    v |= I_TD;
        default: v |= 13'h0000;
      endcase
    end
    drive(v);
  endtask

  initial begin
    // Nominal NUM_LAYERS=2 run; expectations are for the 2-layer instance.
    tbl[0]  = '{I_ST,          mk_out(1, 0, 0, 0, 0, 1, 0, 0)};
    tbl[1]  = '{I_WB,          mk_out(0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[2]  = '{I_WD | I_WNB,  mk_out(1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[3]  = '{I_PV | I_TID1, mk_out(1, 1, 0, 0, 0, 1, 0, 0)};
    tbl[4]  = '{I_WB,          mk_out(0, 1, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{I_WD,          mk_out(1, 2, 0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{I_IB,          mk_out(0, 2, 0, 0, 0, 1, 0, 0)};
    tbl[7]  = '{I_ID,          mk_out(0, 0, 1, 0, 0, 1, 0, 0)};
    tbl[8]  = '{13'h0000,      mk_out(0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[9]  = '{I_CD,          mk_out(1, 0, 0, 0, 1, 1, 0, 0)};
    tbl[10] = '{I_WD | I_WNB,  mk_out(1, 1, 0, 0, 1, 1, 0, 0)};
    tbl[11] = '{I_WD,          mk_out(0, 0, 1, 0, 1, 1, 0, 0)};
    tbl[12] = '{13'h0000,      mk_out(0, 0, 0, 0, 1, 1, 0, 0)};
    tbl[13] = '{I_ST,          mk_out(0, 0, 0, 0, 1, 1, 0, 0)};
    tbl[14] = '{I_TD,          mk_out(0, 0, 0, 0, 1, 1, 0, 0)};
    tbl[15] = '{I_CD,          mk_out(0, 0, 0, 1, 1, 1, 0, 0)};
    tbl[16] = '{13'h0000,      mk_out(0, 0, 0, 0, 1, 1, 0, 0)};
    tbl[17] = '{I_TD,          mk_out(0, 0, 0, 0, 1, 0, 1, 0)};
    tbl[18] = '{13'h0000,      mk_out(0, 0, 0, 0, 1, 0, 0, 0)};

    rst = 1'b1;
    drive(13'h0000);
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    cmp("reset state dut0", get_outs(0), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    cmp("reset state dut1", get_outs(1), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    clear_counts();
    run_table();
    cmp_int("comp_start count L2", cnt_cs[0], 2);
    cmp_int("tx_start count L2", cnt_ts[0], 1);
    cmp_int("seq_done count L2", cnt_done[0], 1);
    cmp_int("comp_start count L1", cnt_cs[1], 1);
    cmp_int("tx_start count L1", cnt_ts[1], 1);
    cmp_int("seq_done count L1", cnt_done[1], 1);

    // Wrong TID while weights are expected.
    drive(I_ST); tick();
    drive(I_PV | I_TID2); tick();
    cmp("wrong tid err", get_outs(0), mk_out(0, 0, 0, 0, 0, 0, 0, 1));
    drive(I_CLR); tick();
    cmp("err_clr to idle", get_outs(0), mk_out(0, 0, 0, 0, 0, 0, 0, 0));

    // Bias completion before weights, then err_clr together with start.
    drive(I_ST); tick();
    drive(I_WD); tick();
    cmp("bias before weights", get_outs(0), mk_out(0, 0, 0, 0, 0, 0, 0, 1));
    drive(I_CLR | I_ST); tick();
    cmp("clr wins over start", get_outs(1), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    drive(13'h0000); tick();
    cmp("start dropped", get_outs(0), mk_out(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset while loading the bias of layer 1.
    drive(I_ST); tick();
    drive(I_WD | I_WNB); tick();
    drive(I_WD); tick();
    drive(I_ID); tick();
    drive(13'h0000); tick();
    drive(I_CD); tick();
    drive(I_WD | I_WNB); tick();
    cmp("LD_B layer1", get_outs(0), mk_out(1, 1, 0, 0, 1, 1, 0, 0));
    drive(13'h0000);
    rst = 1'b1; tick();
    cmp("mid-run reset dut0", get_outs(0), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    cmp("mid-run reset dut1", get_outs(1), mk_out(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    clear_counts();
    run_table();
    cmp_int("rerun seq_done count", cnt_done[0], 1);

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      gen_random();
      tick();
    end
    rst = 1'b0;
    drive(13'h0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
